// File: rtl/bnn_pixel_loader.sv
// rtl/bnn_pixel_loader.sv - packs a binarised pixel byte stream into rows and hands them to the BNN core
// Optional sticky overflow flag on err: define BNN_LOADER_ERR_EN.
module bnn_pixel_loader #(
    parameter int ROW_PIXELS = 28,
    parameter int ROWS       = 28,
    localparam int BYTES_PER_ROW = (ROW_PIXELS + 7) / 8,
    localparam int IDX_W         = $clog2(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic [ROW_PIXELS-1:0] row_data,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [IDX_W-1:0]      row_idx,
    output logic                  row_last,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err
);
    localparam int ASM_W = BYTES_PER_ROW * 8;
    localparam int CNT_W = (BYTES_PER_ROW > 1) ? $clog2(BYTES_PER_ROW) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_ROW - 1);
    localparam logic [IDX_W-1:0] LAST_ROW  = IDX_W'(ROWS - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [IDX_W-1:0]      asm_row_q, asm_row_d;
    logic [ASM_W-1:0]      asm_q, asm_d;
    logic                  pending_q, pending_d;
    logic                  out_valid_q, out_valid_d;
    logic [ROW_PIXELS-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic                  frame_done_q, frame_done_d;
`ifdef BNN_LOADER_ERR_EN
    logic                  err_q, err_d;
    logic                  cur_err;
`endif

    logic [1:0]            cur_state;
    logic [CNT_W-1:0]      cur_byte_cnt;
    logic [IDX_W-1:0]      cur_asm_row;
    logic [ASM_W-1:0]      cur_asm;
    logic                  cur_pending;
    logic                  cur_out_valid;
    logic [ROW_PIXELS-1:0] cur_out_data;
    logic [IDX_W-1:0]      cur_out_idx;
    logic                  handshake;

    always_comb begin
        // frame_start is folded in first so a same-cycle byte lands as byte 0 of the new frame
        cur_state     = state_q;
        cur_byte_cnt  = byte_cnt_q;
        cur_asm_row   = asm_row_q;
        cur_asm       = asm_q;
        cur_pending   = pending_q;
        cur_out_valid = out_valid_q;
        cur_out_data  = out_data_q;
        cur_out_idx   = out_idx_q;
`ifdef BNN_LOADER_ERR_EN
        cur_err       = err_q;
`endif
        if (frame_start) begin
            cur_state     = ST_LOAD;
            cur_byte_cnt  = '0;
            cur_asm_row   = '0;
            cur_asm       = '0;
            cur_pending   = 1'b0;
            cur_out_valid = 1'b0;
            cur_out_data  = '0;
            cur_out_idx   = '0;
`ifdef BNN_LOADER_ERR_EN
            cur_err       = 1'b0;
`endif
        end

        handshake    = cur_out_valid & row_ready;
        state_d      = cur_state;
        byte_cnt_d   = cur_byte_cnt;
        asm_row_d    = cur_asm_row;
        asm_d        = cur_asm;
        pending_d    = cur_pending;
        out_valid_d  = cur_out_valid;
        out_data_d   = cur_out_data;
        out_idx_d    = cur_out_idx;
        frame_done_d = 1'b0;
`ifdef BNN_LOADER_ERR_EN
        err_d        = cur_err;
`endif

        if (handshake) begin
            if (cur_pending) begin
                out_data_d = cur_asm[ROW_PIXELS-1:0];
                out_idx_d  = cur_out_idx + 1'b1;
                pending_d  = 1'b0;
                asm_d      = '0;
            end else begin
                out_valid_d = 1'b0;
            end
            if (cur_state == ST_DRAIN && cur_out_idx == LAST_ROW) begin
                state_d      = ST_IDLE;
                frame_done_d = 1'b1;
            end
        end

        if (cur_state == ST_LOAD && in_valid && !cur_pending) begin
            for (int k = 0; k < BYTES_PER_ROW; k++) begin
                if (cur_byte_cnt == CNT_W'(k)) begin
                    asm_d[8*k +: 8] = in_byte;
                end
            end
            if (cur_byte_cnt == LAST_BYTE) begin
                byte_cnt_d = '0;
                asm_row_d  = (cur_asm_row == LAST_ROW) ? '0 : cur_asm_row + 1'b1;
                if (cur_asm_row == LAST_ROW) begin
                    state_d = ST_DRAIN;
                end
                if (!cur_out_valid || handshake) begin
                    out_valid_d = 1'b1;
                    out_data_d  = asm_d[ROW_PIXELS-1:0];
                    out_idx_d   = cur_asm_row;
                    asm_d       = '0;
                end else begin
                    pending_d = 1'b1;
                end
            end else begin
                byte_cnt_d = cur_byte_cnt + 1'b1;
            end
        end

`ifdef BNN_LOADER_ERR_EN
        if (cur_state != ST_IDLE && in_valid && cur_pending) begin
            err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            byte_cnt_q   <= '0;
            asm_row_q    <= '0;
            asm_q        <= '0;
            pending_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            asm_row_q    <= asm_row_d;
            asm_q        <= asm_d;
            pending_q    <= pending_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef BNN_LOADER_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign row_data   = out_data_q;
    assign row_valid  = out_valid_q;
    assign row_idx    = out_idx_q;
    assign row_last   = out_valid_q & (out_idx_q == LAST_ROW);
    assign frame_done = frame_done_q;
    assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bnn_pixel_loader.sv
// tb/tb_bnn_pixel_loader.sv - self-checking bench for bnn_pixel_loader with a queue-based reference model
module tb_bnn_pixel_loader;
`ifdef BNN_LOADER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk, rst, frame_start, in_valid, row_ready;
    logic [7:0]  in_byte;
    logic [27:0] row_data;
    logic        row_valid, row_last, frame_done, busy, err;
    logic [4:0]  row_idx;

    bnn_pixel_loader dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .in_byte(in_byte), .in_valid(in_valid),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx),
        .row_last(row_last), .frame_done(frame_done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_hs, n_done, n_last;
    logic [27:0] got [28];
    bit chk_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: rows waiting for the core form a queue of at most two (output + pending)
    typedef struct {
        logic [27:0] d;
        int          idx;
    } row_t;
    row_t        mq[$];
    row_t        popped;
    bit          m_active, m_done, m_err, drop;
    int          m_nbytes, m_rows_asm;
    logic [31:0] m_part;

    initial begin
        forever begin
            @(posedge clk);
            m_done = 0;
            if (rst) begin
                mq.delete(); m_active = 0; m_nbytes = 0; m_rows_asm = 0; m_err = 0; m_part = 0;
            end else begin
                if (frame_start) begin
                    mq.delete(); m_active = 1; m_nbytes = 0; m_rows_asm = 0; m_err = 0; m_part = 0;
                end
                drop = (mq.size() == 2);
                if (mq.size() > 0 && row_ready) begin
                    popped = mq.pop_front();
                    if (popped.idx == 27) begin
                        m_active = 0;
                        m_done = 1;
                    end
                end
                if (m_active && in_valid && drop) m_err = ERR_EN;
                if (m_active && m_rows_asm < 28 && in_valid && !drop) begin
                    m_part = m_part | (32'(in_byte) << (8 * m_nbytes));
                    m_nbytes++;
                    if (m_nbytes == 4) begin
                        mq.push_back('{d: m_part[27:0], idx: m_rows_asm});
                        m_rows_asm++;
                        m_nbytes = 0;
                        m_part = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("row_valid", 32'(row_valid), 32'(mq.size() > 0));
                chk("busy", 32'(busy), 32'(m_active));
                chk("frame_done", 32'(frame_done), 32'(m_done));
                chk("err", 32'(err), 32'(m_err));
                chk("row_last", 32'(row_last), 32'(mq.size() > 0 && mq[0].idx == 27));
                if (mq.size() > 0) begin
                    chk("row_data", 32'(row_data), 32'(mq[0].d));
                    chk("row_idx", 32'(row_idx), 32'(mq[0].idx));
                end
                if (row_valid && row_ready && !frame_start && !rst) begin
                    n_hs++;
                    got[row_idx] = row_data;
                    if (row_last) n_last++;
                end
                if (frame_done) n_done++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1; in_byte = b;
        tick();
        in_valid = 0;
    endtask

    task automatic start();
        frame_start = 1;
        tick();
        frame_start = 0;
    endtask

    task automatic clear_stats();
        n_hs = 0; n_done = 0; n_last = 0;
        for (int i = 0; i < 28; i++) got[i] = '0;
    endtask

    task automatic wait_done(input int max);
        int k = 0;
        while (n_done == 0 && k < max) begin
            tick();
            k++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_valid"}, 32'(row_valid), 0);
        chk({tag, "_row_data"}, 32'(row_data), 0);
        chk({tag, "_row_idx"}, 32'(row_idx), 0);
        chk({tag, "_row_last"}, 32'(row_last), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(((i / 4) % 16) * 16 + (i % 4));
    endfunction

    initial begin
        clk = 0; rst = 1; frame_start = 0; in_valid = 0; in_byte = 0; row_ready = 0;
        clear_stats();
        tick(); tick();
        chk_en = 1;
        @(negedge clk);
        chk_reset_vals("reset");
        tick();
        rst = 0;

        // bytes with no frame_start are ignored
        for (int i = 0; i < 8; i++) send(8'hFF);
        @(negedge clk);
        chk("idle_row_valid", 32'(row_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_err", 32'(err), 0);
        tick();

        // full frame, core always ready
        clear_stats();
        row_ready = 1;
        start();
        for (int i = 0; i < 112; i++) send(pat(i));
        wait_done(20);
        @(negedge clk);
        chk("full_rows", 32'(n_hs), 28);
        chk("full_done_pulses", 32'(n_done), 1);
        chk("full_last_count", 32'(n_last), 1);
        chk("full_row5", 32'(got[5]), 32'h0352_5150);
        chk("full_row27", 32'(got[27]), 32'h03B2_B1B0);
        chk("full_busy_after", 32'(busy), 0);
        tick();

        // backpressure: row 0 held, row 1 pending, ninth byte dropped
        clear_stats();
        row_ready = 0;
        start();
        for (int i = 0; i < 9; i++) send(pat(i));
        tick(); tick();
        @(negedge clk);
        chk("bp_row_valid", 32'(row_valid), 1);
        chk("bp_row_idx", 32'(row_idx), 0);
        chk("bp_row_data", 32'(row_data), 32'h0302_0100);
        chk("bp_err", 32'(err), 32'(ERR_EN));
        tick();
        row_ready = 1;
        tick(); tick();
        row_ready = 0;
        @(negedge clk);
        chk("bp_rows_delivered", 32'(n_hs), 2);
        chk("bp_row0", 32'(got[0]), 32'h0302_0100);
        chk("bp_row1", 32'(got[1]), 32'h0312_1110);
        chk("bp_valid_after", 32'(row_valid), 0);
        tick();

        // reset in the middle of a frame
        row_ready = 1;
        start();
        for (int i = 0; i < 6; i++) send(pat(i));
        rst = 1;
        tick(); tick();
        @(negedge clk);
        chk_reset_vals("midrst");
        tick();
        rst = 0;
        for (int i = 0; i < 4; i++) send(8'h5A);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_row_valid", 32'(row_valid), 0);
        tick();

        // padding bits beyond column 27 are discarded
        clear_stats();
        row_ready = 1;
        start();
        send(8'h11); send(8'h22); send(8'h33); send(8'hFF);
        send(8'h44); send(8'h55); send(8'h66); send(8'hF0);
        tick();
        @(negedge clk);
        chk("pad_ff", 32'(got[0]), 32'h0F33_2211);
        chk("pad_f0", 32'(got[1]), 32'h0066_5544);
        tick();

        // abort after 50 bytes; the start-cycle byte becomes byte 0
        row_ready = 1;
        start();
        for (int i = 0; i < 50; i++) send(pat(i));
        frame_start = 1; in_valid = 1; in_byte = 8'hA5;
        tick();
        frame_start = 0; in_valid = 0;
        clear_stats();
        @(negedge clk);
        chk("abort_row_valid", 32'(row_valid), 0);
        chk("abort_err", 32'(err), 0);
        chk("abort_busy", 32'(busy), 1);
        tick();
        for (int i = 1; i < 112; i++) send(8'(i) ^ 8'hA5);
        wait_done(20);
        @(negedge clk);
        chk("abort_rows", 32'(n_hs), 28);
        chk("abort_done_pulses", 32'(n_done), 1);
        chk("abort_row0", 32'(got[0]), 32'h06A7_A4A5);
        chk("abort_row27", 32'(got[27]), 32'h0ACB_C8C9);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
